dat_mem_p: RTL and testbench

Parametrised successor to the 8x256 data memory: a single-clock, single-port-per-direction data RAM with configurable width and depth, a registered read path with a valid strobe, write-first forwarding, and a hardware clear sequencer that initialises every word after reset. It sits between the datapath's load/store unit and the processor core. It replaces the file-loaded, combinational-read memory wherever deterministic post-reset contents and a pipelined load stage are required.

---
 rtl/dat_mem_p.sv | 109 ++++++++++
 tb/tb_dat_mem_p.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dat_mem_p.sv
// Parametrised data RAM with registered read, write-first forwarding and a
// post-reset clear sequencer that writes CLR_VAL into every word.
//
// state | meaning
// CLEAR | sequencer walks ptr over the whole array writing CLR_VAL; requests refused
// READY | normal load/store service
module dat_mem_p #(
  parameter int unsigned      DW      = 8,
  parameter int unsigned      AW      = 8,
  parameter logic [DW-1:0]    CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] dat_in_i,
  output logic [DW-1:0] dat_out_o,
  output logic          rd_valid_o,
  output logic          busy_o,
  output logic          err_o
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t        state_q;
  logic [AW-1:0] ptr_q;
  logic [DW-1:0] dat_out_q;
  logic          rd_valid_q;
  logic          busy_q;
  logic          err_q;

  logic [DW-1:0] mem_q [DEPTH];

  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic          req;

  assign req = wr_en_i | rd_en_i;

  // The sequencer owns the array write port while clearing.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = addr_i;
    mem_wd = dat_in_i;
    if (state_q == CLEAR) begin
      mem_we = 1'b1;
      mem_wa = ptr_q;
      mem_wd = CLR_VAL;
    end else if (wr_en_i) begin
      mem_we = 1'b1;
    end
  end

  // Array storage carries no reset; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      ptr_q      <= '0;
      dat_out_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          rd_valid_q <= 1'b0;
          err_q      <= req;
          ptr_q      <= ptr_q + AW'(1);
          if (ptr_q == {AW{1'b1}}) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          err_q      <= 1'b0;
          busy_q     <= 1'b0;
          rd_valid_q <= rd_en_i;
          if (rd_en_i) begin
            dat_out_q <= wr_en_i ? dat_in_i : mem_q[addr_i];
          end
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign dat_out_o  = dat_out_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_dat_mem_p.sv
// Bench for dat_mem_p: directed stimulus with a read-data scoreboard
// drained by an independent monitor on the falling clock edge.
module tb_dat_mem_p;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam logic [7:0] CV = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] dat_in = '0;
  logic [DW-1:0] dat_out;
  logic          rd_valid;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [$];
  int pushed = 0;
  int popped = 0;

  always #5 clk = ~clk;

  dat_mem_p #(.DW(DW), .AW(AW), .CLR_VAL(CV)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .rd_en_i(rd_en),
    .addr_i(addr), .dat_in_i(dat_in), .dat_out_o(dat_out),
    .rd_valid_o(rd_valid), .busy_o(busy), .err_o(err)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: rd_valid with dat_out %0h, no read outstanding", dat_out);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        popped++;
        if (dat_out !== e) begin
          n_fail++;
          $display("FAIL rd_data: got %0h, expected %0h", dat_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; addr = a; dat_in = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd_en = 1'b1; addr = a;
    exp_q.push_back(e); pushed++;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  int n;
  logic [7:0] vals [4];

  initial begin
    vals[0] = 8'hC0; vals[1] = 8'h5A; vals[2] = 8'h0F; vals[3] = 8'hE7;

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_dat_out", dat_out, 0);
    check("rst_err", err, 0);

    // Clear with an illegal write at edge 10
    rst_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      tick();
      n++;
      if (n == 9) begin
        wr_en = 1'b1; addr = 8'd5; dat_in = 8'hFF;
      end else if (n == 10) begin
        wr_en = 1'b0;
        check("err_pulse", err, 1);
      end else if (n == 11) begin
        check("err_clear", err, 0);
      end
    end
    check("clear_cycles", n, 256);
    check("busy_after_clear", busy, 0);

    rd(8'd0, CV);
    rd(8'd127, CV);
    rd(8'd255, CV);
    rd(8'd5, CV);
    tick();

    // Basic write/read and hold
    wr(8'h10, 8'h3C);
    rd(8'h10, 8'h3C);
    tick();
    check("hold_rd_valid", rd_valid, 0);
    check("hold_dat_out", dat_out, 8'h3C);
    addr = 8'h20;
    tick();
    check("hold_no_follow", dat_out, 8'h3C);

    // Same-cycle forwarding
    wr(8'h20, 8'h11);
    wr_en = 1'b1; rd_en = 1'b1; addr = 8'h20; dat_in = 8'h77;
    exp_q.push_back(8'h77); pushed++;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    rd(8'h20, 8'h77);
    tick();

    // Back-to-back reads
    for (int i = 0; i < 4; i++) wr(AW'(i), vals[i]);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; addr = AW'(i);
      exp_q.push_back(vals[i]); pushed++;
      tick();
      check("b2b_rd_valid", rd_valid, 1);
    end
    rd_en = 1'b0;
    tick();
    check("b2b_end_rd_valid", rd_valid, 0);

    // Asynchronous reset from READY, then reset mid-clear
    rst_n = 1'b0;
    #1;
    check("async_busy_ready", busy, 1);
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    check("midclear_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midclear_async_busy", busy, 1);
    tick();
    rst_n = 1'b1;
    wait_clear(n);
    check("reclear_cycles", n, 256);
    rd(8'd200, CV);
    rd(8'h10, CV);
    rd(8'h20, CV);
    tick();

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("reads_drained", popped, pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
